mem_access_stage: RTL

//  MEM stage of the 5-stage RV32I pipeline; consumes the EX/MEM register (ALU result, store data, branch target, controls).

---
 rtl/pipe_pkg.sv | 47 ++++
 rtl/load_store_align.sv | 44 ++++
 rtl/mem_access_stage.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline encodings for decode, execute and the memory-access stage.
// Also holds the branch-resolution helper used by MEM.
package pipe_pkg;

  localparam logic [1:0] MEMRW_NONE  = 2'b00;
  localparam logic [1:0] MEMRW_LOAD  = 2'b01;
  localparam logic [1:0] MEMRW_STORE = 2'b10;

  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM = 2'b01;
  localparam logic [1:0] MEMTOREG_PC4 = 2'b10;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_EQ   = 3'b001;
  localparam logic [2:0] BR_NE   = 3'b010;
  localparam logic [2:0] BR_LT   = 3'b011;
  localparam logic [2:0] BR_JALR = 3'b100;
  localparam logic [2:0] BR_GE   = 3'b101;
  localparam logic [2:0] BR_JAL  = 3'b110;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } mem_state_e;

  // EX already reduced the comparison to an SLT/SLTU or subtract result.
  function automatic logic br_taken(input logic [2:0] kind, input logic [31:0] alu);
    case (kind)
      BR_EQ, BR_GE:    return alu == 32'd0;
      BR_NE:           return alu != 32'd0;
      BR_LT:           return alu == 32'd1;
      BR_JAL, BR_JALR: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for stores and sign/zero extension for loads.
// Also flags accesses whose address is not aligned to their size.
module load_store_align
  import pipe_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

  // funct3[1:0] is the access size, funct3[2] selects zero extension.
  always_comb begin
    wdata_o      = store_data_i;
    wstrb_o      = 4'b1111;
    load_data_o  = rdata_i;
    misaligned_o = 1'b0;
    case (funct3_i[1:0])
      2'b00: begin
        wdata_o     = {4{store_data_i[7:0]}};
        wstrb_o     = 4'b0001 << addr_lo_i;
        load_data_o = funct3_i[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      2'b01: begin
        wdata_o      = {2{store_data_i[15:0]}};
        wstrb_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        load_data_o  = funct3_i[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
        misaligned_o = addr_lo_i[0];
      end
      default: misaligned_o = addr_lo_i != 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: branch redirect, data-memory req/gnt/rvalid handshake with timeout,
// load extension and the MEM/WB register. Stalls EX while an access is open.
module mem_access_stage
  import pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int WAIT_LIMIT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_branch_i,
  input  logic [XLEN-1:0] pcp4_i,
  input  logic [XLEN-1:0] alu_res_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [4:0]      wreg_i,
  input  logic            regwrite_i,
  input  logic [1:0]      memtoreg_i,
  input  logic [1:0]      memrw_i,
  input  logic [2:0]      membranch_i,
  input  logic [31:0]     instr_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [3:0]      dmem_wstrb_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            stall_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic [4:0]      wb_wreg_o,
  output logic            wb_regwrite_o,
  output logic [31:0]     wb_instr_o,
  output logic            exc_o
);

  localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (WAIT_LIMIT > 0) ? CNT_W'(WAIT_LIMIT - 1) : '0;
  localparam bit HAS_LIMIT = WAIT_LIMIT > 0;

  mem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d, redirect_pc_q, redirect_pc_d;
  logic [4:0]      wb_wreg_q, wb_wreg_d;
  logic [31:0]     wb_instr_q, wb_instr_d;
  logic            wb_regwrite_q, wb_regwrite_d, redirect_q, redirect_d, exc_q, exc_d;

  logic [31:0] lane_wdata, load_data;
  logic [3:0]  lane_wstrb;
  logic        misaligned, is_load, is_store, mem_op;
  logic        req, complete, abort, active, stall, kill;

  load_store_align u_align (
    .funct3_i     (instr_i[14:12]),
    .addr_lo_i    (alu_res_i[1:0]),
    .store_data_i (store_data_i),
    .rdata_i      (dmem_rdata_i),
    .wdata_o      (lane_wdata),
    .wstrb_o      (lane_wstrb),
    .load_data_o  (load_data),
    .misaligned_o (misaligned)
  );

  assign is_load  = memrw_i == MEMRW_LOAD;
  assign is_store = memrw_i == MEMRW_STORE;
  assign mem_op   = is_load || is_store;

  // A load that sees rvalid together with gnt finishes without visiting WAIT.
  always_comb begin
    state_d  = state_q;
    req      = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op && !misaligned) begin
          req = 1'b1;
          if (dmem_gnt_i && (is_store || dmem_rvalid_i)) complete = 1'b1;
          else if (dmem_gnt_i)                           state_d  = ST_WAIT;
          else                                           state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        req = 1'b1;
        if (dmem_gnt_i && (is_store || dmem_rvalid_i)) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end else if (dmem_gnt_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid_i) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (HAS_LIMIT && state_q != ST_IDLE && !complete && cnt_q == CNT_LAST) begin
      abort   = 1'b1;
      state_d = ST_IDLE;
    end
    cnt_d = (state_q != ST_IDLE && state_d != ST_IDLE) ? cnt_q + 1'b1 : '0;
  end

  assign active = (state_q != ST_IDLE) || (mem_op && !misaligned);
  assign stall  = active && !complete && !abort;
  assign kill   = abort || (state_q == ST_IDLE && mem_op && misaligned);

  // Stalled, misaligned and aborted cycles all hand WB a bubble.
  always_comb begin
    wb_data_d     = '0;
    wb_wreg_d     = '0;
    wb_regwrite_d = 1'b0;
    wb_instr_d    = '0;
    redirect_d    = 1'b0;
    redirect_pc_d = '0;
    exc_d         = kill;
    if (!stall && !kill) begin
      wb_wreg_d     = wreg_i;
      wb_regwrite_d = regwrite_i && (wreg_i != 5'd0);
      wb_instr_d    = instr_i;
      case (memtoreg_i)
        MEMTOREG_ALU: wb_data_d = alu_res_i;
        MEMTOREG_MEM: wb_data_d = load_data;
        MEMTOREG_PC4: wb_data_d = pcp4_i;
        default:      wb_data_d = '0;
      endcase
      if (memrw_i == MEMRW_NONE && br_taken(membranch_i, alu_res_i)) begin
        redirect_d    = 1'b1;
        redirect_pc_d = pc_branch_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      wb_data_q     <= '0;
      wb_wreg_q     <= '0;
      wb_regwrite_q <= 1'b0;
      wb_instr_q    <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      exc_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wb_data_q     <= wb_data_d;
      wb_wreg_q     <= wb_wreg_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_instr_q    <= wb_instr_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      exc_q         <= exc_d;
    end
  end

  // Reset gates the combinational handshake so a held EX op cannot raise req.
  assign dmem_req_o    = rst && req;
  assign dmem_we_o     = rst && req && is_store;
  assign dmem_addr_o   = {alu_res_i[XLEN-1:2], 2'b00};
  assign dmem_wdata_o  = lane_wdata;
  assign dmem_wstrb_o  = is_store ? lane_wstrb : 4'b0000;
  assign stall_o       = rst && stall;
  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;
  assign wb_data_o     = wb_data_q;
  assign wb_wreg_o     = wb_wreg_q;
  assign wb_regwrite_o = wb_regwrite_q;
  assign wb_instr_o    = wb_instr_q;
  assign exc_o         = exc_q;

endmodule
